// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request/response front end.
package fpu_pkg;

   localparam int unsigned FP_WIDTH = 32;

   // Returned in place of a result when the FPU never finishes.
   localparam logic [FP_WIDTH-1:0] FP_QNAN = 32'h7FC00000;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_RESP  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/fpu_watchdog.sv
// Watchdog for the WAIT state: 16-bit up-counter with synchronous clear and
// an expiry flag when the count reaches TIMEOUT_CYCLES-1.
module fpu_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count;

   // Counter: clear wins over enable; holds once expired so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 16'd1;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/fpu_dispatch.sv
// Valid/ready front end for the FPU: latches a request, holds start until the
// FPU finishes (or the watchdog fires), returns the result, then waits for
// finish to drop before accepting the next request.
module fpu_dispatch
   import fpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   // request channel
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [FP_WIDTH-1:0] req_a,
   input  logic [FP_WIDTH-1:0] req_b,
   input  logic                req_mul,
   // response channel
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [FP_WIDTH-1:0] rsp_s,
   output logic                rsp_err,
   // FPU side
   output logic [FP_WIDTH-1:0] fpu_a,
   output logic [FP_WIDTH-1:0] fpu_b,
   output logic                fpu_multiplicando,
   output logic                fpu_start,
   input  logic [FP_WIDTH-1:0] fpu_s,
   input  logic                fpu_finish
);

   state_e state_q, state_d;
   logic   accept;
   logic   in_wait;
   logic   wd_expired;

   assign req_ready = (state_q == ST_IDLE);
   assign accept    = req_valid & req_ready;
   assign in_wait   = (state_q == ST_WAIT);
   assign fpu_start = in_wait;
   assign rsp_valid = (state_q == ST_RESP);

   fpu_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept),
      .enable (in_wait),
      .expired(wd_expired)
   );

   // Next-state logic; finish takes priority over a coincident timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_valid)               state_d = ST_WAIT;
         ST_WAIT:  if (fpu_finish || wd_expired) state_d = ST_RESP;
         ST_RESP:  if (rsp_ready)               state_d = ST_DRAIN;
         ST_DRAIN: if (!fpu_finish)             state_d = ST_IDLE;
         default:                               state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand registers: loaded only on request acceptance, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpu_a             <= '0;
         fpu_b             <= '0;
         fpu_multiplicando <= OP_ADD;
      end else if (accept) begin
         fpu_a             <= req_a;
         fpu_b             <= req_b;
         fpu_multiplicando <= req_mul;
      end
   end

   // Result registers: written only when leaving WAIT, stable through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_s   <= '0;
         rsp_err <= 1'b0;
      end else if (in_wait) begin
         if (fpu_finish) begin
            rsp_s   <= fpu_s;
            rsp_err <= 1'b0;
         end else if (wd_expired) begin
            rsp_s   <= FP_QNAN;
            rsp_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch with a behavioural FPU stub whose latency,
// finish hold time and "never finish" mode are set per test.
module tb_fpu_dispatch;
   import fpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_mul;
   logic [31:0] req_a, req_b;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_s;
   logic [31:0] fpu_a, fpu_b, fpu_s;
   logic        fpu_multiplicando, fpu_start;
   logic        fpu_finish = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // stub controls
   int stub_lat   = 3;
   int stub_hold  = 0;
   bit stub_never = 1'b0;
   int scnt = 0;
   int hcnt = 0;

   fpu_dispatch #(
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_a            (req_a),
      .req_b            (req_b),
      .req_mul          (req_mul),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_s            (rsp_s),
      .rsp_err          (rsp_err),
      .fpu_a            (fpu_a),
      .fpu_b            (fpu_b),
      .fpu_multiplicando(fpu_multiplicando),
      .fpu_start        (fpu_start),
      .fpu_s            (fpu_s),
      .fpu_finish       (fpu_finish)
   );

   always #5 clk = ~clk;

   // Hand-computed results for the operand pairs used below.
   function automatic logic [31:0] stub_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic mul);
      if (a == 32'h3E800000 && b == 32'h3F000000) return mul ? 32'h3E000000 : 32'h3F400000;
      if (a == 32'h3F800000 && b == 32'h3F800000) return mul ? 32'h3F800000 : 32'h40000000;
      return 32'hDEADBEEF;
   endfunction

   assign fpu_s = stub_result(fpu_a, fpu_b, fpu_multiplicando);

   // FPU stub: finish rises stub_lat edges after start is seen, and stays high
   // for stub_hold extra edges after start falls.
   always @(posedge clk) begin
      if (fpu_start) begin
         hcnt <= 0;
         scnt <= scnt + 1;
         if (!stub_never && (scnt + 1 == stub_lat)) fpu_finish <= 1'b1;
      end else begin
         scnt <= 0;
         if (fpu_finish) begin
            if (hcnt >= stub_hold) fpu_finish <= 1'b0;
            else hcnt <= hcnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic mul);
      int guard = 0;
      while (!req_ready && guard < 100) begin
         tick();
         guard++;
      end
      req_a     = a;
      req_b     = b;
      req_mul   = mul;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      while (!rsp_valid && cyc < 64) begin
         tick();
         cyc++;
      end
   endtask

   // Completes the response handshake and counts DRAIN cycles until req_ready.
   task automatic handshake(input string tag, output int drain);
      rsp_ready = 1'b1;
      tick();
      check({tag, "_valid_drop"}, rsp_valid, 1'b0);
      drain = 0;
      while (!req_ready && drain < 64) begin
         tick();
         drain++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, 1'b1);
      check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check({tag, "_rsp_s"}, rsp_s, 32'h0);
      check({tag, "_rsp_err"}, rsp_err, 1'b0);
      check({tag, "_start"}, fpu_start, 1'b0);
      check({tag, "_fpu_a"}, fpu_a, 32'h0);
      check({tag, "_fpu_b"}, fpu_b, 32'h0);
      check({tag, "_mul"}, fpu_multiplicando, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int c, d;
      bit bad;
      rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_mul = 1'b0;
      rsp_ready = 1'b0;
      #3;
      check_reset_outputs("rst");
      #4 rst_n = 1'b1;
      tick();

      // add, 3-cycle FPU
      rsp_ready = 1'b1; stub_lat = 3;
      do_req(32'h3E800000, 32'h3F000000, OP_ADD);
      check("add_start", fpu_start, 1'b1);
      check("add_fpu_a", fpu_a, 32'h3E800000);
      check("add_fpu_b", fpu_b, 32'h3F000000);
      check("add_op", fpu_multiplicando, OP_ADD);
      wait_rsp(c);
      check("add_latency", c, 4);
      check("add_start_low", fpu_start, 1'b0);
      check("add_s", rsp_s, 32'h3F400000);
      check("add_err", rsp_err, 1'b0);
      handshake("add", d);
      check("add_drain", d, 1);

      // multiply, 2-cycle FPU
      stub_lat = 2;
      do_req(32'h3E800000, 32'h3F000000, OP_MUL);
      check("mul_op", fpu_multiplicando, OP_MUL);
      wait_rsp(c);
      check("mul_latency", c, 3);
      check("mul_s", rsp_s, 32'h3E000000);
      check("mul_err", rsp_err, 1'b0);
      handshake("mul", d);

      // timeout, then a normal request afterwards
      stub_never = 1'b1;
      do_req(32'h3E800000, 32'h3F000000, OP_ADD);
      wait_rsp(c);
      check("to_latency", c, 8);
      check("to_s", rsp_s, 32'h7FC00000);
      check("to_err", rsp_err, 1'b1);
      handshake("to", d);
      check("to_drain", d, 1);
      stub_never = 1'b0; stub_lat = 3;
      do_req(32'h3E800000, 32'h3F000000, OP_ADD);
      wait_rsp(c);
      check("after_to_s", rsp_s, 32'h3F400000);
      check("after_to_err", rsp_err, 1'b0);
      handshake("after_to", d);

      // back-pressure: 20 cycles of rsp_ready low with a competing request
      rsp_ready = 1'b0; stub_lat = 1;
      do_req(32'h3F800000, 32'h3F800000, OP_ADD);
      wait_rsp(c);
      check("bp_latency", c, 2);
      req_a = 32'h12345678; req_valid = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_s !== 32'h40000000 || req_ready !== 1'b0) bad = 1'b1;
      end
      req_valid = 1'b0;
      check("bp_stable", bad, 1'b0);
      check("bp_no_accept", fpu_a, 32'h3F800000);
      check("bp_s", rsp_s, 32'h40000000);
      handshake("bp", d);

      // drain: FPU keeps finish high 3 cycles after start falls
      stub_lat = 2; stub_hold = 3;
      do_req(32'h3E800000, 32'h3F000000, OP_MUL);
      wait_rsp(c);
      check("dr_s", rsp_s, 32'h3E000000);
      handshake("dr", d);
      check("dr_drain", d, 4);
      check("dr_finish_low", fpu_finish, 1'b0);
      stub_hold = 0;

      // finish first high on the timeout cycle
      stub_lat = 7;
      do_req(32'h3F800000, 32'h3F800000, OP_ADD);
      wait_rsp(c);
      check("co_latency", c, 8);
      check("co_s", rsp_s, 32'h40000000);
      check("co_err", rsp_err, 1'b0);
      handshake("co", d);

      // asynchronous reset in the middle of WAIT
      stub_never = 1'b1;
      do_req(32'h3E800000, 32'h3F000000, OP_ADD);
      tick();
      tick();
      check("mr_in_wait", fpu_start, 1'b1);
      rst_n = 1'b0;
      #2;
      check_reset_outputs("mr");
      #3 rst_n = 1'b1;
      stub_never = 1'b0; stub_lat = 2;
      do_req(32'h3F800000, 32'h3F800000, OP_ADD);
      check("mr_accept", fpu_start, 1'b1);
      wait_rsp(c);
      check("mr_latency", c, 3);
      check("mr_s", rsp_s, 32'h40000000);
      check("mr_err", rsp_err, 1'b0);
      handshake("mr", d);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
